// File: rtl/k_lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states,
// access-size decode and the store/misalignment classification helpers.
package k_lsu_pkg;

  // Memory operation codes presented by EX/MEM.
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  // Controller states; the unit is only ready to accept in ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4
  } lsu_state_t;

  // Width of the data touched by an operation.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  function automatic lsu_size_t op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Unsigned loads zero-extend; everything else sign-extends (stores ignore it).
  function automatic logic op_unsigned(input logic [2:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes always fit.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/k_lsu_lane.sv
// Combinational lane logic for a big-endian word: extracts and extends the
// addressed byte/halfword for loads, and merges the low store byte/halfword
// into the addressed lane for read-modify-write stores.
module k_lsu_lane
  import k_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  input  logic [15:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  lsu_size_t   size;
  logic        zext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign size = op_size(op);
  assign zext = op_unsigned(op);

  // Select the addressed lane; offset 0 is the most significant byte.
  always_comb begin
    byte_lane = word[31:24];
    case (offset)
      2'd0:    byte_lane = word[31:24];
      2'd1:    byte_lane = word[23:16];
      2'd2:    byte_lane = word[15:8];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected lane to a full word for the writeback path.
  always_comb begin
    load_value = word;
    case (size)
      SZ_BYTE: load_value = zext ? {24'h000000, byte_lane}
                                 : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_value = zext ? {16'h0000, half_lane}
                                 : {{16{half_lane[15]}}, half_lane};
      default: load_value = word;
    endcase
  end

  // Overlay the store byte/halfword onto the word just read from memory.
  always_comb begin
    merged_word = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged_word[31:24] = store_data[7:0];
          2'd1:    merged_word[23:16] = store_data[7:0];
          2'd2:    merged_word[15:8]  = store_data[7:0];
          default: merged_word[7:0]   = store_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged_word[15:0]  = store_data;
        else           merged_word[31:16] = store_data;
      end
      default: merged_word = word;
    endcase
  end

endmodule

// File: rtl/k_load_store_unit.sv
// Load/store unit between EX/MEM and a word-wide data memory. One operation
// at a time; sub-word stores are done as read-modify-write; misaligned
// requests are answered with an error and never reach memory.
module k_load_store_unit
  import k_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              K_clk,
  input  logic              K_reset,
  input  logic              K_req_valid,
  output logic              K_req_ready,
  input  logic [2:0]        K_req_op,
  input  logic [ADDR_W-1:0] K_req_addr,
  input  logic [DATA_W-1:0] K_req_store_data,
  output logic              K_resp_valid,
  output logic [DATA_W-1:0] K_resp_data,
  output logic              K_addr_error,
  output logic [ADDR_W-1:0] K_mem_addr,
  output logic [DATA_W-1:0] K_mem_write_data,
  output logic              K_MemWrite,
  input  logic [DATA_W-1:0] K_mem_read_data
);

  lsu_state_t  state;
  logic        accept;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] store_q;
  logic [31:0] load_value;
  logic [31:0] merged_word;

  assign K_req_ready = (state == ST_IDLE);
  assign accept      = K_req_valid && K_req_ready;

  // Both the load path and the RMW read path use the same lane logic,
  // driven by the request fields captured at accept.
  k_lsu_lane u_lane (
    .word        (K_mem_read_data),
    .offset      (off_q),
    .op          (op_q),
    .store_data  (store_q),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  // Capture the request fields needed after accept; upstream may change them.
  always_ff @(posedge K_clk) begin
    if (accept) begin
      op_q    <= K_req_op;
      off_q   <= K_req_addr[1:0];
      store_q <= K_req_store_data[15:0];
    end
  end

  // Controller FSM with registered memory strobes and response outputs.
  // The write strobe is raised on the edge entering WRITE/RMW_WRITE so it is
  // high for exactly that one state; reset drops it along with everything else.
  always_ff @(posedge K_clk) begin
    if (K_reset) begin
      state            <= ST_IDLE;
      K_resp_valid     <= 1'b0;
      K_resp_data      <= '0;
      K_addr_error     <= 1'b0;
      K_MemWrite       <= 1'b0;
      K_mem_addr       <= '0;
      K_mem_write_data <= '0;
    end else begin
      K_resp_valid <= 1'b0;
      K_resp_data  <= '0;
      K_addr_error <= 1'b0;
      K_MemWrite   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_misaligned(K_req_op, K_req_addr[1:0])) begin
              K_resp_valid <= 1'b1;
              K_addr_error <= 1'b1;
            end else begin
              K_mem_addr <= {K_req_addr[ADDR_W-1:2], 2'b00};
              if (K_req_op == OP_SW) begin
                K_mem_write_data <= K_req_store_data;
                K_MemWrite       <= 1'b1;
                state            <= ST_WRITE;
              end else if (is_store(K_req_op)) begin
                state <= ST_RMW_READ;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
        end
        ST_LOAD: begin
          K_resp_valid <= 1'b1;
          K_resp_data  <= load_value;
          state        <= ST_IDLE;
        end
        ST_WRITE: begin
          K_resp_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        ST_RMW_READ: begin
          K_mem_write_data <= merged_word;
          K_MemWrite       <= 1'b1;
          state            <= ST_RMW_WRITE;
        end
        ST_RMW_WRITE: begin
          K_resp_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k_load_store_unit.sv
// Self-checking bench for k_load_store_unit: a directed vector table, a
// byte-array reference model for random traffic, and hand-written
// back-to-back and reset-abort sequences.
module tb_k_load_store_unit;

  localparam logic [2:0] T_LB  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LW  = 3'b010;
  localparam logic [2:0] T_SW  = 3'b011;
  localparam logic [2:0] T_LBU = 3'b100;
  localparam logic [2:0] T_LHU = 3'b101;
  localparam logic [2:0] T_SB  = 3'b110;
  localparam logic [2:0] T_SH  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        addr_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  // Word memory seen by the DUT, and byte-addressed reference image.
  logic [31:0] mem [64] = '{default: 32'h0};
  logic [7:0]  rb  [256] = '{default: 8'h0};

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_write_data;
  end

  k_load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .K_clk            (clk),
    .K_reset          (rst),
    .K_req_valid      (req_valid),
    .K_req_ready      (req_ready),
    .K_req_op         (req_op),
    .K_req_addr       (req_addr),
    .K_req_store_data (req_store_data),
    .K_resp_valid     (resp_valid),
    .K_resp_data      (resp_data),
    .K_addr_error     (addr_error),
    .K_mem_addr       (mem_addr),
    .K_mem_write_data (mem_write_data),
    .K_MemWrite       (mem_write),
    .K_mem_read_data  (mem_read_data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_misaligned(input logic [2:0] op, input logic [31:0] a);
    if (op == T_LH || op == T_LHU || op == T_SH) return a[0];
    if (op == T_LW || op == T_SW) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic ref_is_store(input logic [2:0] op);
    return op == T_SW || op == T_SB || op == T_SH;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
    case (op)
      T_LB:    return {{24{rb[a][7]}}, rb[a]};
      T_LBU:   return {24'h0, rb[a]};
      T_LH:    return {{16{rb[a][7]}}, rb[a], rb[a+1]};
      T_LHU:   return {16'h0, rb[a], rb[a+1]};
      default: return {rb[a], rb[a+1], rb[a+2], rb[a+3]};
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] op, input int a, input logic [31:0] d);
    if (op == T_SB) begin
      rb[a] = d[7:0];
    end else if (op == T_SH) begin
      rb[a] = d[15:8]; rb[a+1] = d[7:0];
    end else if (op == T_SW) begin
      rb[a] = d[31:24]; rb[a+1] = d[23:16]; rb[a+2] = d[15:8]; rb[a+3] = d[7:0];
    end
  endtask

  // Issue one request from a negedge, then watch up to 8 cycles for the
  // response, counting write strobes and checking their address.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic rerr, output int lat,
                        output int nwr, output logic addr_ok);
    rdata = 32'h0; rerr = 1'b0; lat = 0; nwr = 0; addr_ok = 1'b1;
    req_valid = 1'b1; req_op = op; req_addr = a; req_store_data = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_store_data = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_write) begin
        nwr++;
        if (mem_addr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
      end
      if (resp_valid) begin
        lat = c; rdata = resp_data; rerr = addr_error;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [31:0] rdata;
    logic        rerr;
    int          lat;
    int          nwr;
    logic        addr_ok;

    vt[0]  = '{T_SW,  32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 1};
    vt[1]  = '{T_LW,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0};
    vt[2]  = '{T_LB,  32'h11, 32'h0,        1'b0, 32'hFFFFFFAD, 2, 0};
    vt[3]  = '{T_LBU, 32'h11, 32'h0,        1'b0, 32'h000000AD, 2, 0};
    vt[4]  = '{T_LH,  32'h12, 32'h0,        1'b0, 32'hFFFFBEEF, 2, 0};
    vt[5]  = '{T_LHU, 32'h10, 32'h0,        1'b0, 32'h0000DEAD, 2, 0};
    vt[6]  = '{T_SB,  32'h13, 32'h12345677, 1'b0, 32'h00000000, 3, 1};
    vt[7]  = '{T_LW,  32'h10, 32'h0,        1'b0, 32'hDEADBE77, 2, 0};
    vt[8]  = '{T_SH,  32'h12, 32'h0000CAFE, 1'b0, 32'h00000000, 3, 1};
    vt[9]  = '{T_LW,  32'h10, 32'h0,        1'b0, 32'hDEADCAFE, 2, 0};
    vt[10] = '{T_LW,  32'h06, 32'h0,        1'b1, 32'h00000000, 1, 0};
    vt[11] = '{T_SH,  32'h11, 32'h0000BEEF, 1'b1, 32'h00000000, 1, 0};
    vt[12] = '{T_LHU, 32'h03, 32'h0,        1'b1, 32'h00000000, 1, 0};

    rst = 1'b1; req_valid = 1'b0; req_op = 3'h0; req_addr = 32'h0; req_store_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready",      {31'h0, req_ready},  32'h1);
    check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset_resp_data",  resp_data,           32'h0);
    check("reset_addr_error", {31'h0, addr_error}, 32'h0);
    check("reset_memwrite",   {31'h0, mem_write},  32'h0);
    check("reset_mem_addr",   mem_addr,            32'h0);
    check("reset_wdata",      mem_write_data,      32'h0);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].addr, vt[i].data, rdata, rerr, lat, nwr, addr_ok);
      check($sformatf("vec%0d_lat", i),   lat,            vt[i].lat);
      check($sformatf("vec%0d_data", i),  rdata,          vt[i].rdata);
      check($sformatf("vec%0d_err", i),   {31'h0, rerr},  {31'h0, vt[i].err});
      check($sformatf("vec%0d_nwr", i),   nwr,            vt[i].nwr);
      check($sformatf("vec%0d_waddr", i), {31'h0, addr_ok}, 32'h1);
      if (!vt[i].err && ref_is_store(vt[i].op)) ref_store(vt[i].op, int'(vt[i].addr), vt[i].data);
    end

    // Random traffic against the byte-array model.
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      logic        eerr;
      logic [31:0] edata;
      int          elat;
      int          enwr;
      op = 3'($urandom);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (op == T_LW || op == T_SW) a[1:0] = 2'b00;
        else if (op == T_LH || op == T_LHU || op == T_SH) a[0] = 1'b0;
      end
      d = $urandom;
      eerr  = ref_misaligned(op, a);
      edata = (eerr || ref_is_store(op)) ? 32'h0 : ref_load(op, int'(a));
      elat  = eerr ? 1 : ((op == T_SB || op == T_SH) ? 3 : 2);
      enwr  = (!eerr && ref_is_store(op)) ? 1 : 0;
      run_op(op, a, d, rdata, rerr, lat, nwr, addr_ok);
      check($sformatf("rnd%0d_lat", n),  lat,           elat);
      check($sformatf("rnd%0d_data", n), rdata,         edata);
      check($sformatf("rnd%0d_err", n),  {31'h0, rerr}, {31'h0, eerr});
      check($sformatf("rnd%0d_nwr", n),  nwr,           enwr);
      check($sformatf("rnd%0d_waddr", n), {31'h0, addr_ok}, 32'h1);
      if (!eerr && ref_is_store(op)) ref_store(op, int'(a), d);
    end

    // Back-to-back LW, SW, LB with valid held high.
    begin
      logic [2:0]  sop [3];
      logic [31:0] sad [3];
      logic [31:0] sdt [3];
      logic [31:0] sexp [3];
      int          ecyc [3];
      int          idx;
      int          nresp;
      int          bwr;
      logic        acc;
      sop[0] = T_LW; sad[0] = 32'h20; sdt[0] = 32'h0;
      sop[1] = T_SW; sad[1] = 32'h24; sdt[1] = 32'hA1B2C3D4;
      sop[2] = T_LB; sad[2] = 32'h25; sdt[2] = 32'h0;
      sexp[0] = ref_load(T_LW, 32'h20);
      sexp[1] = 32'h0;
      ref_store(T_SW, 32'h24, 32'hA1B2C3D4);
      sexp[2] = ref_load(T_LB, 32'h25);
      ecyc[0] = 2; ecyc[1] = 4; ecyc[2] = 6;
      idx = 0; nresp = 0; bwr = 0;
      req_valid = 1'b1; req_op = sop[0]; req_addr = sad[0]; req_store_data = sdt[0];
      for (int c = 1; c <= 20 && nresp < 3; c++) begin
        acc = req_ready && req_valid;
        @(negedge clk);
        if (mem_write) bwr++;
        if (resp_valid) begin
          check($sformatf("b2b%0d_data", nresp), resp_data, sexp[nresp]);
          check($sformatf("b2b%0d_cycle", nresp), c, ecyc[nresp]);
          nresp++;
        end
        if (acc) begin
          idx++;
          if (idx < 3) begin
            req_op = sop[idx]; req_addr = sad[idx]; req_store_data = sdt[idx];
          end else begin
            req_valid = 1'b0;
          end
        end
      end
      req_valid = 1'b0;
      check("b2b_responses", nresp, 3);
      check("b2b_writes", bwr, 1);
    end

    // Reset pulsed during the RMW read of an SB aborts it.
    begin
      int awr;
      int arsp;
      awr = 0; arsp = 0;
      run_op(T_SW, 32'h30, 32'h11223344, rdata, rerr, lat, nwr, addr_ok);
      ref_store(T_SW, 32'h30, 32'h11223344);
      req_valid = 1'b1; req_op = T_SB; req_addr = 32'h31; req_store_data = 32'h000000EE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_ready", {31'h0, req_ready}, 32'h1);
      for (int c = 0; c < 5; c++) begin
        if (mem_write) awr++;
        if (resp_valid) arsp++;
        @(negedge clk);
      end
      check("abort_writes", awr, 0);
      check("abort_resps", arsp, 0);
      check("abort_mem_word", mem[12], 32'h11223344);
      run_op(T_LW, 32'h30, 32'h0, rdata, rerr, lat, nwr, addr_ok);
      check("abort_readback", rdata, ref_load(T_LW, 32'h30));
    end

    // Final image of the DUT-side memory against the byte model.
    for (int w = 0; w < 64; w++) begin
      check($sformatf("mem_word%0d", w), mem[w],
            {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
